// File: rtl/missile_pkg.sv
// Shared types and constants for the player-missile fire controller.
// The MISSILE_AUTOFIRE_EN build option is consumed by missile_fire_ctrl.
package missile_pkg;

    typedef enum logic [1:0] {
        READY    = 2'd0,
        FIRE     = 2'd1,
        COOLDOWN = 2'd2
    } fire_state_t;

    localparam logic [7:0] KEY_SPACE     = 8'd44;
    localparam logic [9:0] SCREEN_X_MAX  = 10'd639;
    localparam int         DEF_NUM_SLOTS = 4;

    // Launch point: widened by one bit so the offset cannot wrap, then clamped to the screen.
    function automatic logic [9:0] launch_point(input logic [9:0] ship_x, input logic [10:0] offset);
        logic [10:0] sum;
        sum = {1'b0, ship_x} + offset;
        return (sum > {1'b0, SCREEN_X_MAX}) ? SCREEN_X_MAX : sum[9:0];
    endfunction

endpackage

// File: rtl/missile_fire_ctrl_if.sv
// Keyboard/ship inputs and missile-pool outputs of the fire controller.
// master = environment driving keys and releases, slave = the controller.
interface missile_fire_ctrl_if #(parameter int NUM_SLOTS = missile_pkg::DEF_NUM_SLOTS);

    logic [7:0]           keycode;
    logic [9:0]           ship_x;
    logic [NUM_SLOTS-1:0] slot_release;
    logic [NUM_SLOTS-1:0] slot_create;
    logic [9:0]           launch_x;
    logic [NUM_SLOTS-1:0] slot_busy;
    logic                 ready;
    logic [15:0]          shots_fired;

    modport master (
        output keycode, ship_x, slot_release,
        input  slot_create, launch_x, slot_busy, ready, shots_fired
    );

    modport slave (
        input  keycode, ship_x, slot_release,
        output slot_create, launch_x, slot_busy, ready, shots_fired
    );

endinterface

// File: rtl/missile_fire_ctrl_picker.sv
// rr_slot_picker: combinational rotate-priority picker; grants the first free
// slot at or above rr_ptr, wrapping modulo NUM_SLOTS.
module rr_slot_picker #(
    parameter int NUM_SLOTS = 4,
    parameter int PTR_W     = 2
) (
    input  logic [NUM_SLOTS-1:0] busy,
    input  logic [PTR_W-1:0]     rr_ptr,
    output logic [NUM_SLOTS-1:0] grant,
    output logic                 valid
);

    localparam int SW = PTR_W + 1;

    logic [SW-1:0]    sum;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            sum = {1'b0, rr_ptr} + SW'(k);
            if (sum >= SW'(NUM_SLOTS)) begin
                sum = sum - SW'(NUM_SLOTS);
            end
            idx = sum[PTR_W-1:0];
            if (!valid && !busy[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/missile_fire_ctrl.sv
// Spacebar fire controller with frame cooldown and round-robin missile slot allocation.
// Build option MISSILE_AUTOFIRE_EN: level-sensitive spacebar (autofire) instead of edge.
module missile_fire_ctrl
    import missile_pkg::*;
#(
    parameter int NUM_SLOTS       = DEF_NUM_SLOTS,
    parameter int COOLDOWN_FRAMES = 15,
    parameter int LAUNCH_OFFSET   = 8
) (
    input  logic                 frame_clk,
    input  logic                 Reset_n,
    missile_fire_ctrl_if.slave   bus,
    output fire_state_t          dbg_state
);

    localparam int PTR_W = $clog2(NUM_SLOTS);

    fire_state_t          state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_SLOTS-1:0] slot_create_q, slot_create_d;
    logic [NUM_SLOTS-1:0] slot_busy_q, slot_busy_d;
    logic [9:0]           launch_x_q, launch_x_d;
    logic [15:0]          shots_q, shots_d;

    logic                 space;
    logic                 fire_req;
    logic [NUM_SLOTS-1:0] pick_grant;
    logic                 pick_valid;
    logic [PTR_W-1:0]     pick_idx;

    assign space = (bus.keycode == KEY_SPACE);

`ifdef MISSILE_AUTOFIRE_EN
    assign fire_req = space;
`else
    logic prev_space_q, prev_space_d;
    assign prev_space_d = space;
    assign fire_req     = space && !prev_space_q;

    always_ff @(posedge frame_clk) begin
        if (!Reset_n) prev_space_q <= 1'b0;
        else          prev_space_q <= prev_space_d;
    end
`endif

    // A slot released this edge still reads busy here; it becomes pickable next cycle.
    rr_slot_picker #(.NUM_SLOTS(NUM_SLOTS), .PTR_W(PTR_W)) u_picker (
        .busy   (slot_busy_q),
        .rr_ptr (rr_ptr_q),
        .grant  (pick_grant),
        .valid  (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (pick_grant[i]) pick_idx = PTR_W'(i);
        end
    end

    // Handshake: a fire request is accepted only on an edge where ready is high;
    // otherwise it is dropped. slot_create is a one-cycle valid with no backpressure.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rr_ptr_d      = rr_ptr_q;
        slot_create_d = slot_create_q;
        slot_busy_d   = slot_busy_q & ~bus.slot_release;
        launch_x_d    = launch_x_q;
        shots_d       = shots_q;
        case (state_q)
            READY: begin
                if (fire_req && pick_valid) begin
                    state_d       = FIRE;
                    slot_create_d = pick_grant;
                    slot_busy_d   = slot_busy_d | pick_grant;
                    launch_x_d    = launch_point(bus.ship_x, 11'(LAUNCH_OFFSET));
                    shots_d       = shots_q + 16'd1;
                    rr_ptr_d      = (pick_idx == PTR_W'(NUM_SLOTS - 1)) ? '0 : pick_idx + PTR_W'(1);
                end
            end
            FIRE: begin
                state_d       = COOLDOWN;
                cnt_d         = 8'(COOLDOWN_FRAMES);
                slot_create_d = '0;
            end
            COOLDOWN: begin
                if (cnt_q == 8'd0) state_d = READY;
                else               cnt_d   = cnt_q - 8'd1;
            end
            default: state_d = READY;
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (!Reset_n) begin
            state_q       <= READY;
            cnt_q         <= '0;
            rr_ptr_q      <= '0;
            slot_create_q <= '0;
            slot_busy_q   <= '0;
            launch_x_q    <= '0;
            shots_q       <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rr_ptr_q      <= rr_ptr_d;
            slot_create_q <= slot_create_d;
            slot_busy_q   <= slot_busy_d;
            launch_x_q    <= launch_x_d;
            shots_q       <= shots_d;
        end
    end

    assign bus.slot_create = slot_create_q;
    assign bus.slot_busy   = slot_busy_q;
    assign bus.launch_x    = launch_x_q;
    assign bus.shots_fired = shots_q;
    assign bus.ready       = (state_q == READY) && (|(~slot_busy_q));
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_missile_fire_ctrl.sv
// Scoreboard bench for missile_fire_ctrl: randomized keys/releases against a
// cycle-count reference model; follows MISSILE_AUTOFIRE_EN when defined.
module tb_missile_fire_ctrl;
    import missile_pkg::*;

    localparam int N   = 4;
    localparam int CD  = 15;
    localparam int OFF = 8;
    localparam int W   = N + 10 + 16;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    missile_fire_ctrl_if #(.NUM_SLOTS(N)) bus ();
    fire_state_t dbg_state;

    missile_fire_ctrl #(
        .NUM_SLOTS       (N),
        .COOLDOWN_FRAMES (CD),
        .LAUNCH_OFFSET   (OFF)
    ) dut (
        .frame_clk (clk),
        .Reset_n   (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // scoreboard
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;
    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // reference model: a shot locks the launcher for CD+3 edges; slots are a busy set
    logic [N-1:0] m_busy;
    int m_rr, m_shots, m_lx, m_ready_at, m_edges;
    bit m_prev;

    task automatic model_reset();
        m_busy     = '0;
        m_rr       = 0;
        m_shots    = 0;
        m_lx       = 0;
        m_ready_at = 0;
        m_edges    = 0;
        m_prev     = 1'b0;
    endtask

    // Called at a negedge: check current outputs, apply inputs, predict the next edge.
    task automatic step(input logic [7:0] key, input logic [9:0] sx, input logic [N-1:0] rel);
        bit in_ready, space, req, fire, found;
        int idx, cand;
        logic [N-1:0] grant;
        in_ready = (m_edges >= m_ready_at);
        chk("slot_busy", 32'(bus.slot_busy), 32'(m_busy));
        chk("ready", 32'(bus.ready), 32'(in_ready && (m_busy != '1)));
        chk("state_ready", 32'(dbg_state == READY), 32'(in_ready));
        chk("launch_x_held", 32'(bus.launch_x), 32'(m_lx));
        chk("shots_fired", 32'(bus.shots_fired), 32'(m_shots));

        bus.keycode      = key;
        bus.ship_x       = sx;
        bus.slot_release = rel;

        space = (key == KEY_SPACE);
`ifdef MISSILE_AUTOFIRE_EN
        req = space;
`else
        req = space && !m_prev;
`endif
        m_prev = space;
        fire   = req && in_ready && (m_busy != '1);
        grant  = '0;
        idx    = 0;
        found  = 1'b0;
        if (fire) begin
            for (int k = 0; k < N; k++) begin
                cand = (m_rr + k) % N;
                if (!found && (((m_busy >> cand) & N'(1)) == '0)) begin
                    idx   = cand;
                    found = 1'b1;
                end
            end
            grant = N'(1) << idx;
        end
        m_busy = (m_busy & ~rel) | grant;
        if (fire) begin
            m_rr       = (idx + 1) % N;
            m_shots    = (m_shots + 1) % 65536;
            m_lx       = (int'(sx) + OFF > 639) ? 639 : int'(sx) + OFF;
            m_ready_at = m_edges + 1 + CD + 2;
            exp_q.push_back({grant, 10'(m_lx), 16'(m_shots)});
        end
        m_edges++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(8'd0, 10'($urandom_range(0, 1023)), '0);
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        bus.keycode      = 8'd0;
        bus.ship_x       = 10'd0;
        bus.slot_release = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        chk("rst_slot_create", 32'(bus.slot_create), 32'd0);
        chk("rst_slot_busy", 32'(bus.slot_busy), 32'd0);
        chk("rst_launch_x", 32'(bus.launch_x), 32'd0);
        chk("rst_shots", 32'(bus.shots_fired), 32'd0);
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_state", 32'(dbg_state == READY), 32'd1);
    endtask

    // monitor: every create pulse must match the oldest predicted shot
    always @(negedge clk) begin
        if (bus.slot_create != '0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_create", 32'(bus.slot_create), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("create_onehot", 32'(bus.slot_create), 32'(mon_e[W-1:26]));
                chk("create_launch_x", 32'(bus.launch_x), 32'(mon_e[25:16]));
                chk("create_shots", 32'(bus.shots_fired), 32'(mon_e[15:0]));
            end
        end
    end

    initial begin
        logic [7:0]   k;
        logic [N-1:0] r;
        bus.keycode      = 8'd0;
        bus.ship_x       = 10'd0;
        bus.slot_release = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        // single tap at x=100, then cooldown
        step(KEY_SPACE, 10'd100, '0);
        idle(20);

        // held spacebar
        repeat (100) step(KEY_SPACE, 10'd200, '0);
        idle(20);

        // fill remaining slots, then a press with all slots busy
        step(KEY_SPACE, 10'd300, '0);
        idle(20);
        step(KEY_SPACE, 10'd400, '0);
        idle(20);
        step(KEY_SPACE, 10'd500, '0);
        idle(3);

        // free slot 2, then fire near the right edge (clamp)
        step(8'd0, 10'd0, N'(4'b0100));
        idle(2);
        step(KEY_SPACE, 10'd635, '0);
        idle(20);

        // release on the same edge as allocating the next slot
        do_reset();
        step(KEY_SPACE, 10'd50, '0);
        idle(20);
        step(KEY_SPACE, 10'd60, N'(4'b0001));
        idle(20);

        // random traffic
        repeat (800) begin
            k = ($urandom_range(0, 2) == 0) ? KEY_SPACE : 8'($urandom_range(0, 255));
            r = ($urandom_range(0, 9) == 0) ? N'($urandom_range(0, (1 << N) - 1)) : '0;
            step(k, 10'($urandom_range(0, 1023)), r);
        end

        // reset while the create pulse is out
        step(8'd0, 10'd0, '1);
        idle(20);
        step(KEY_SPACE, 10'd10, '0);
        do_reset();
        idle(5);

        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
